// File: rtl/pcpi_div_arbiter.sv
// pcpi_div_arbiter: round-robin share of one PCPI divider between two requesters (PCPI_DIV_ARB_WDOG_EN adds an issue watchdog)
module pcpi_div_arbiter #(
  parameter int TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req0_valid,
  input  logic [31:0] req0_insn,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_rs2,
  output logic        req0_wr,
  output logic [31:0] req0_rd,
  output logic        req0_wait,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_insn,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_rs2,
  output logic        req1_wr,
  output logic [31:0] req1_rd,
  output logic        req1_wait,
  output logic        req1_ready,
  output logic        div_valid,
  output logic [31:0] div_insn,
  output logic [31:0] div_rs1,
  output logic [31:0] div_rs2,
  input  logic        div_wr,
  input  logic [31:0] div_rd,
  input  logic        div_wait,
  input  logic        div_ready,
  output logic        wdog_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d, wr_q, wr_d, gnt, wdog_hit;
  logic [1:0] armed_q, armed_d, wait_q, wait_d, valid, is_div, pend, resp;
  logic [31:0] insn_q, insn_d, rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  assign valid = {req1_valid, req0_valid};
  assign is_div = {req1_valid && req1_insn[6:0] == 7'h33 && req1_insn[31:25] == 7'h01 && req1_insn[14],
                   req0_valid && req0_insn[6:0] == 7'h33 && req0_insn[31:25] == 7'h01 && req0_insn[14]};
  assign pend = is_div & armed_q;
  assign resp = {state_q == RESP && owner_q, state_q == RESP && !owner_q};
  assign gnt = &pend ? ~last_q : pend[1];
  assign armed_d = ~valid | (armed_q & ~resp);
  assign wait_d = pend & ~resp;
`ifdef PCPI_DIV_ARB_WDOG_EN
  logic [31:0] cnt_q;
  logic wdog_q;
  assign wdog_hit = state_q == ISSUE && !div_ready && cnt_q == 32'(TIMEOUT - 1);
  assign wdog_err = wdog_q;
  // Cycles spent in the current issue, and the sticky timeout flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
      wdog_q <= 1'b0;
    end else begin
      cnt_q <= state_q == ISSUE ? cnt_q + 32'd1 : '0;
      wdog_q <= wdog_q | wdog_hit;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wdog_hit = 1'b0;
  assign wdog_err = 1'b0;
`endif
  // Grant, hold the divider request, then return its result to the owner for one cycle
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    insn_d = insn_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    wr_d = wr_q;
    rd_d = rd_q;
    case (state_q)
      IDLE: if (|pend && !div_wait) begin
        state_d = ISSUE;
        owner_d = gnt;
        last_d = gnt;
        insn_d = gnt ? req1_insn : req0_insn;
        rs1_d = gnt ? req1_rs1 : req0_rs1;
        rs2_d = gnt ? req1_rs2 : req0_rs2;
      end
      ISSUE: if (div_ready || wdog_hit) begin
        state_d = RESP;
        wr_d = div_ready & div_wr;
        rd_d = div_ready ? div_rd : '0;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State, latched operands, arm flags and registered wait
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q <= 1'b1;
      armed_q <= 2'b11;
      wait_q <= 2'b00;
      insn_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      wr_q <= 1'b0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      armed_q <= armed_d;
      wait_q <= wait_d;
      insn_q <= insn_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  assign div_valid = state_q == ISSUE;
  assign div_insn = insn_q;
  assign div_rs1 = rs1_q;
  assign div_rs2 = rs2_q;
  assign req0_ready = resp[0];
  assign req0_wr = resp[0] & wr_q;
  assign req0_rd = resp[0] ? rd_q : '0;
  assign req0_wait = wait_q[0];
  assign req1_ready = resp[1];
  assign req1_wr = resp[1] & wr_q;
  assign req1_rd = resp[1] ? rd_q : '0;
  assign req1_wait = wait_q[1];
endmodule

// File: tb/tb_pcpi_div_arbiter.sv
// tb_pcpi_div_arbiter: directed vectors and corner sequences for pcpi_div_arbiter (watchdog part under PCPI_DIV_ARB_WDOG_EN)
module tb_pcpi_div_arbiter;
  localparam logic [31:0] DIV  = {7'h01, 5'd2, 5'd1, 3'd4, 5'd3, 7'h33};
  localparam logic [31:0] DIVU = {7'h01, 5'd2, 5'd1, 3'd5, 5'd3, 7'h33};
  localparam logic [31:0] REM  = {7'h01, 5'd2, 5'd1, 3'd6, 5'd3, 7'h33};
  localparam logic [31:0] REMU = {7'h01, 5'd2, 5'd1, 3'd7, 5'd3, 7'h33};
  localparam logic [31:0] ADD  = {7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};
  localparam logic [31:0] MUL  = {7'h01, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};
  localparam logic [31:0] IMM  = {7'h01, 5'd2, 5'd1, 3'd5, 5'd3, 7'h13};

  typedef struct {
    int          port;
    logic        is_div;
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp_rd;
  } vec_t;

  logic clk = 1'b0, resetn = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_insn = '0, req0_rs1 = '0, req0_rs2 = '0;
  logic [31:0] req1_insn = '0, req1_rs1 = '0, req1_rs2 = '0;
  logic req0_wr, req0_wait, req0_ready, req1_wr, req1_wait, req1_ready;
  logic [31:0] req0_rd, req1_rd, div_insn, div_rs1, div_rs2;
  logic div_valid, wdog_err;
  logic div_wr, div_ready;
  logic [31:0] div_rd;
  logic div_wait = 1'b0;
  logic stub_en = 1'b1;
  logic stub_busy;
  int stub_cnt;
  int n_cmp = 0, n_bad = 0;
  int gap, nres, prev, n;
  logic ok, seen0, ok1, wait_drop;
  vec_t tbl[9];

  pcpi_div_arbiter dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_insn(req0_insn), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
    .req0_wr(req0_wr), .req0_rd(req0_rd), .req0_wait(req0_wait), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_insn(req1_insn), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
    .req1_wr(req1_wr), .req1_rd(req1_rd), .req1_wait(req1_wait), .req1_ready(req1_ready),
    .div_valid(div_valid), .div_insn(div_insn), .div_rs1(div_rs1), .div_rs2(div_rs2),
    .div_wr(div_wr), .div_rd(div_rd), .div_wait(div_wait), .div_ready(div_ready),
    .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] quot(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    case (insn[13:12])
      2'b00: return $signed(a) / $signed(b);
      2'b01: return a / b;
      2'b10: return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  // Divider stub: answers each new request four cycles after first seeing it
  always @(posedge clk) begin
    if (!resetn) begin
      stub_busy <= 1'b0;
      stub_cnt <= 0;
      div_ready <= 1'b0;
      div_wr <= 1'b0;
      div_rd <= '0;
    end else begin
      div_ready <= 1'b0;
      div_wr <= 1'b0;
      div_rd <= '0;
      if (stub_busy) begin
        if (stub_cnt == 0) begin
          stub_busy <= 1'b0;
          div_ready <= 1'b1;
          div_wr <= 1'b1;
          div_rd <= quot(div_insn, div_rs1, div_rs2);
        end else stub_cnt <= stub_cnt - 1;
      end else if (div_valid && !div_ready && stub_en) begin
        stub_busy <= 1'b1;
        stub_cnt <= 3;
      end
    end
  end

  function automatic logic rdy(input int p); return p != 0 ? req1_ready : req0_ready; endfunction
  function automatic logic wt(input int p); return p != 0 ? req1_wait : req0_wait; endfunction
  function automatic logic wrf(input int p); return p != 0 ? req1_wr : req0_wr; endfunction
  function automatic logic [31:0] rdf(input int p); return p != 0 ? req1_rd : req0_rd; endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_valid(input int p, input logic v);
    if (p == 0) req0_valid = v;
    else req1_valid = v;
  endtask

  task automatic drive(input int p, input logic v, input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin
      req0_valid = v; req0_insn = insn; req0_rs1 = a; req0_rs2 = b;
    end else begin
      req1_valid = v; req1_insn = insn; req1_rs1 = a; req1_rs2 = b;
    end
  endtask

  task automatic wait_ready(input int p, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (rdy(p)) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic run_op(input int p, input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    logic s;
    drive(p, 1'b1, insn, a, b);
    tick();
    check("issue_wait", wt(p), 1);
    check("issue_valid", div_valid, 1);
    check("issue_insn", div_insn, insn);
    check("issue_rs1", div_rs1, a);
    check("issue_rs2", div_rs2, b);
    wait_ready(p, s);
    check("ready_seen", s, 1);
    check("result_rd", rdf(p), exp);
    check("result_wr", wrf(p), 1);
    check("other_idle", {wt(1 - p), rdy(1 - p), wrf(1 - p), rdf(1 - p)}, 0);
    drive(p, 1'b0, insn, a, b);
    tick();
    check("ready_pulse", rdy(p), 0);
  endtask

  task automatic run_nondiv(input int p, input logic [31:0] insn);
    drive(p, 1'b1, insn, 32'd9, 32'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("nondiv_quiet", {wt(p), rdy(p), div_valid}, 0);
    end
    drive(p, 1'b0, insn, 32'd9, 32'd4);
    tick();
  endtask

  initial begin
    tbl[0] = '{0, 1'b1, DIVU, 32'd100, 32'd7, 32'd14};
    tbl[1] = '{1, 1'b1, REMU, 32'd100, 32'd7, 32'd2};
    tbl[2] = '{0, 1'b1, DIV, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA};
    tbl[3] = '{1, 1'b1, REM, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE};
    tbl[4] = '{1, 1'b1, DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF};
    tbl[5] = '{0, 1'b1, REMU, 32'h80000000, 32'd7, 32'd2};
    tbl[6] = '{1, 1'b0, ADD, 32'd0, 32'd0, 32'd0};
    tbl[7] = '{1, 1'b0, MUL, 32'd0, 32'd0, 32'd0};
    tbl[8] = '{0, 1'b0, IMM, 32'd0, 32'd0, 32'd0};

    tick();
    tick();
    check("rst_req0", {req0_wait, req0_ready, req0_wr, req0_rd}, 0);
    check("rst_req1", {req1_wait, req1_ready, req1_wr, req1_rd}, 0);
    check("rst_div", {div_valid, div_insn}, 0);
    check("rst_ops", {div_rs1, div_rs2}, 0);
    check("rst_wdog", wdog_err, 0);
    resetn = 1'b1;
    tick();

    drive(0, 1'b1, DIVU, 32'd100, 32'd7);
    drive(1, 1'b1, REMU, 32'd100, 32'd7);
    tick();
    check("sim_wait0", req0_wait, 1);
    check("sim_wait1", req1_wait, 1);
    check("sim_first_insn", div_insn, DIVU);
    gap = 0; seen0 = 1'b0; ok1 = 1'b0; wait_drop = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (req1_ready) begin
        ok1 = 1'b1;
        break;
      end
      if (!req1_wait) wait_drop = 1'b1;
      if (req0_ready) begin
        seen0 = 1'b1;
        check("sim_rd0", req0_rd, 32'd14);
        check("sim_wr0", req0_wr, 1);
        req0_valid = 1'b0;
      end else if (seen0 && !div_valid) gap++;
    end
    check("sim_ready0_first", seen0, 1);
    check("sim_ready1_seen", ok1, 1);
    check("sim_wait1_held", wait_drop, 0);
    check("sim_rd1", req1_rd, 32'd2);
    check("sim_valid_gap", gap >= 1, 1);
    drive(1, 1'b0, REMU, 32'd100, 32'd7);
    tick();

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].is_div) run_op(tbl[i].port, tbl[i].insn, tbl[i].rs1, tbl[i].rs2, tbl[i].exp_rd);
      else run_nondiv(tbl[i].port, tbl[i].insn);
    end

    drive(0, 1'b1, DIV, 32'hFFFFFFEC, 32'd3);
    drive(1, 1'b1, DIV, 32'hFFFFFFEC, 32'd3);
    nres = 0;
    prev = -1;
    for (int i = 0; i < 300 && nres < 6; i++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        if (rdy(p)) begin
          check("fair_rd", rdf(p), 32'hFFFFFFFA);
          if (prev >= 0) check("fair_alt", p, 1 - prev);
          prev = p;
          nres++;
          set_valid(p, 1'b0);
        end else set_valid(p, 1'b1);
      end
    end
    check("fair_count", nres, 6);
    set_valid(0, 1'b0);
    set_valid(1, 1'b0);
    tick();
    tick();

    drive(0, 1'b1, DIVU, 32'd100, 32'd7);
    tick();
    wait_ready(0, ok);
    check("held_ready", ok, 1);
    check("held_rd", req0_rd, 32'd14);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_no_reissue", {div_valid, req0_wait, req0_ready}, 0);
    end
    drive(0, 1'b0, DIVU, 32'd100, 32'd7);
    tick();

    div_wait = 1'b1;
    drive(0, 1'b1, DIVU, 32'd100, 32'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("blocked_valid", div_valid, 0);
      check("blocked_wait", req0_wait, 1);
    end
    div_wait = 1'b0;
    tick();
    check("unblock_valid", div_valid, 1);
    wait_ready(0, ok);
    check("unblock_ready", ok, 1);
    check("unblock_rd", req0_rd, 32'd14);
    drive(0, 1'b0, DIVU, 32'd100, 32'd7);
    tick();

    drive(1, 1'b1, DIVU, 32'd100, 32'd7);
    tick();
    req1_valid = 1'b0;
    wait_ready(1, ok);
    check("drop_still_ready", ok, 1);
    tick();
    check("drop_idle", {div_valid, req1_wait, req1_ready}, 0);

    drive(1, 1'b1, REMU, 32'd100, 32'd7);
    tick();
    check("pre_rst_valid", div_valid, 1);
    resetn = 1'b0;
    tick();
    check("rst_mid_req1", {req1_wait, req1_ready, req1_wr, req1_rd}, 0);
    check("rst_mid_div", {div_valid, div_insn}, 0);
    check("rst_mid_ops", {div_rs1, div_rs2}, 0);
    resetn = 1'b1;
    drive(1, 1'b0, REMU, 32'd100, 32'd7);
    tick();
    run_op(1, REMU, 32'd100, 32'd7, 32'd2);

`ifdef PCPI_DIV_ARB_WDOG_EN
    stub_en = 1'b0;
    drive(1, 1'b1, DIVU, 32'd100, 32'd7);
    tick();
    check("wdog_issue", div_valid, 1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (req1_ready) break;
      tick();
      n++;
    end
    check("wdog_latency", n, 63);
    check("wdog_result", {req1_ready, req1_wr, req1_rd}, {1'b1, 33'd0});
    drive(1, 1'b0, DIVU, 32'd100, 32'd7);
    tick();
    check("wdog_err_set", wdog_err, 1);
    stub_en = 1'b1;
    run_op(0, DIVU, 32'd100, 32'd7, 32'd14);
    check("wdog_err_sticky", wdog_err, 1);
`else
    check("wdog_tied", wdog_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
